// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
//
// Shared types and default sizes for the program/data RAM arbiter.
//   arbState_t : arbiter FSM states (IDLE, ISSUE, RDWAIT, HALT)
//   portSel_t  : which requester owns the access in flight (PORT_C, PORT_D)
//   cntWidth() : bits needed to hold a count from 0 up to a given limit
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int ADDR_W_DEF       = 8;
    localparam int DATA_W_DEF       = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        HALT   = 2'd3
    } arbState_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } portSel_t;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cntWidth(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
//
// Saturating up-counter that tracks how many consecutive arbitration rounds
// the debug port has lost to the CPU port.
//
// Ports:
//   i_clk    in   system clock, rising edge
//   i_reset  in   synchronous active-low reset
//   i_clear  in   return the count to zero (has priority over i_inc)
//   i_inc    in   count one lost round; holds once LIMIT is reached
//   o_full   out  count has reached LIMIT
// ---------------------------------------------------------------------------
module starve_counter
    import ram_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_full
);

    localparam int CNT_W = cntWidth(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_inc && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

    assign o_full = (count == LIMIT_V);

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares the single-port program/data RAM between the CPU control path
// (port C) and the debug/program-loader port (port D). One access is in
// flight at a time; the RAM command is driven from registers latched at
// grant time, and read data is returned together with a one-cycle done
// pulse on the port that owned the access.
//
// Ports:
//   i_clk, i_reset             clock (rising edge), sync active-low reset
//   i_cReq/i_cWe/i_cAddr/i_cWData   CPU request, held until o_cDone
//   o_cDone, o_cRData          CPU completion pulse and read data
//   o_cpuStall                 freezes the control step counter
//   i_dReq/i_dWe/i_dAddr/i_dWData   debug request, held until o_dDone
//   o_dDone, o_dRData          debug completion pulse and read data
//   i_dHalt, o_halted          loader halt request / CPU frozen, D owns RAM
//   o_ramAddr/o_ramWe/o_ramWData    RAM command
//   i_ramRData                 RAM read data, one cycle after the address
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate between C and D; a halt request diverts to HALT
// ISSUE  | RAM command on the bus; writes complete here
// RDWAIT | RAM read data arrives; read completes here
// HALT   | CPU frozen; only D is granted, accesses return here
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_cReq,
    input  logic              i_cWe,
    input  logic [ADDR_W-1:0] i_cAddr,
    input  logic [DATA_W-1:0] i_cWData,
    output logic              o_cDone,
    output logic [DATA_W-1:0] o_cRData,
    output logic              o_cpuStall,

    input  logic              i_dReq,
    input  logic              i_dWe,
    input  logic [ADDR_W-1:0] i_dAddr,
    input  logic [DATA_W-1:0] i_dWData,
    output logic              o_dDone,
    output logic [DATA_W-1:0] o_dRData,

    input  logic              i_dHalt,
    output logic              o_halted,

    output logic [ADDR_W-1:0] o_ramAddr,
    output logic              o_ramWe,
    output logic [DATA_W-1:0] o_ramWData,
    input  logic [DATA_W-1:0] i_ramRData
);

    arbState_t         state;
    arbState_t         stateNext;
    portSel_t          sel;
    logic              haltMode;
    logic              haltNext;

    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [DATA_W-1:0] wDataQ;
    logic [DATA_W-1:0] cRDataQ;
    logic [DATA_W-1:0] dRDataQ;

    logic              grantC;
    logic              grantD;
    logic              starveFull;
    logic              starveInc;
    logic              starveClear;
    logic              accessDone;

    // -----------------------------------------------------------------------
    // Starvation tracking: D loses a round only when it was asking and C
    // took the grant. Any D grant, or D not asking, resets the tally.
    // -----------------------------------------------------------------------
    assign starveInc   = grantC && i_dReq;
    assign starveClear = grantD || !i_dReq;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (starveClear),
        .i_inc   (starveInc),
        .o_full  (starveFull)
    );

    // -----------------------------------------------------------------------
    // Next-state and grant logic
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        haltNext  = haltMode;
        grantC    = 1'b0;
        grantD    = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_dHalt) begin
                    stateNext = HALT;
                    haltNext  = 1'b1;
                end else if (i_dReq && starveFull) begin
                    grantD    = 1'b1;
                    stateNext = ISSUE;
                end else if (i_cReq) begin
                    grantC    = 1'b1;
                    stateNext = ISSUE;
                end else if (i_dReq) begin
                    grantD    = 1'b1;
                    stateNext = ISSUE;
                end
            end

            ISSUE: begin
                if (weQ) begin
                    // A halt raised while this access was in flight takes
                    // effect as soon as it finishes.
                    stateNext = i_dHalt ? HALT : IDLE;
                    haltNext  = i_dHalt;
                end else begin
                    stateNext = RDWAIT;
                end
            end

            RDWAIT: begin
                stateNext = i_dHalt ? HALT : IDLE;
                haltNext  = i_dHalt;
            end

            HALT: begin
                if (!i_dHalt) begin
                    stateNext = IDLE;
                    haltNext  = 1'b0;
                end else if (i_dReq) begin
                    grantD    = 1'b1;
                    stateNext = ISSUE;
                end
            end

            default: begin
                stateNext = IDLE;
                haltNext  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, command latch and read-data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= IDLE;
            haltMode <= 1'b0;
            sel      <= PORT_C;
            addrQ    <= '0;
            weQ      <= 1'b0;
            wDataQ   <= '0;
            cRDataQ  <= '0;
            dRDataQ  <= '0;
        end else begin
            state    <= stateNext;
            haltMode <= haltNext;

            if (grantD) begin
                sel    <= PORT_D;
                addrQ  <= i_dAddr;
                weQ    <= i_dWe;
                wDataQ <= i_dWData;
            end else if (grantC) begin
                sel    <= PORT_C;
                addrQ  <= i_cAddr;
                weQ    <= i_cWe;
                wDataQ <= i_cWData;
            end

            if (state == RDWAIT) begin
                if (sel == PORT_C) begin
                    cRDataQ <= i_ramRData;
                end else begin
                    dRDataQ <= i_ramRData;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    //
    // Done and write-enable are gated by reset so that an access aborted by
    // reset neither signals completion nor writes the RAM in its last cycle.
    // Read data is forwarded straight from the RAM during RDWAIT so it is
    // valid alongside done; the captured copy holds it afterwards.
    // -----------------------------------------------------------------------
    assign accessDone = i_reset && (((state == ISSUE) && weQ) || (state == RDWAIT));

    assign o_cDone = accessDone && (sel == PORT_C);
    assign o_dDone = accessDone && (sel == PORT_D);

    assign o_cRData = ((state == RDWAIT) && (sel == PORT_C)) ? i_ramRData : cRDataQ;
    assign o_dRData = ((state == RDWAIT) && (sel == PORT_D)) ? i_ramRData : dRDataQ;

    assign o_ramAddr  = addrQ;
    assign o_ramWData = wDataQ;
    assign o_ramWe    = i_reset && (state == ISSUE) && weQ;

    assign o_halted = haltMode;

    // The halt request itself stalls the CPU so no step advances between the
    // loader asking and the FSM actually reaching HALT.
    assign o_cpuStall = (i_cReq && !o_cDone) || haltMode || i_dHalt;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              i_clk;
    logic              i_reset;
    logic              i_cReq;
    logic              i_cWe;
    logic [ADDR_W-1:0] i_cAddr;
    logic [DATA_W-1:0] i_cWData;
    logic              o_cDone;
    logic [DATA_W-1:0] o_cRData;
    logic              o_cpuStall;
    logic              i_dReq;
    logic              i_dWe;
    logic [ADDR_W-1:0] i_dAddr;
    logic [DATA_W-1:0] i_dWData;
    logic              o_dDone;
    logic [DATA_W-1:0] o_dRData;
    logic              i_dHalt;
    logic              o_halted;
    logic [ADDR_W-1:0] o_ramAddr;
    logic              o_ramWe;
    logic [DATA_W-1:0] o_ramWData;
    logic [DATA_W-1:0] ramRData = '0;

    int testCount = 0;
    int failCount = 0;

    ram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cReq     (i_cReq),
        .i_cWe      (i_cWe),
        .i_cAddr    (i_cAddr),
        .i_cWData   (i_cWData),
        .o_cDone    (o_cDone),
        .o_cRData   (o_cRData),
        .o_cpuStall (o_cpuStall),
        .i_dReq     (i_dReq),
        .i_dWe      (i_dWe),
        .i_dAddr    (i_dAddr),
        .i_dWData   (i_dWData),
        .o_dDone    (o_dDone),
        .o_dRData   (o_dRData),
        .i_dHalt    (i_dHalt),
        .o_halted   (o_halted),
        .o_ramAddr  (o_ramAddr),
        .o_ramWe    (o_ramWe),
        .o_ramWData (o_ramWData),
        .i_ramRData (ramRData)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM model: one-cycle synchronous read, preloaded on the first edge.
    logic [DATA_W-1:0] mem [256];
    logic ramInit = 1'b0;

    always @(posedge i_clk) begin
        if (!ramInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
            ramInit <= 1'b1;
        end else begin
            if (o_ramWe) mem[o_ramAddr] <= o_ramWData;
            ramRData <= mem[o_ramAddr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    logic [7:0] rdAddr [3];
    logic [7:0] rdExp  [3];

    initial begin
        i_reset = 1'b0;
        i_cReq = 1'b0; i_cWe = 1'b0; i_cAddr = '0; i_cWData = '0;
        i_dReq = 1'b0; i_dWe = 1'b0; i_dAddr = '0; i_dWData = '0;
        i_dHalt = 1'b0;
        rdAddr[0] = 8'h01; rdExp[0] = 8'h02;
        rdAddr[1] = 8'h03; rdExp[1] = 8'h04;
        rdAddr[2] = 8'h10; rdExp[2] = 8'hA5;

        adv(); adv();
        mid();
        check("por_cDone",  o_cDone, 0);
        check("por_stall",  o_cpuStall, 0);
        check("por_halted", o_halted, 0);
        adv();

        // Start a C read, then reset it while in RDWAIT
        i_reset = 1'b1; i_cReq = 1'b1; i_cWe = 1'b0; i_cAddr = 8'h40;
        mid(); check("abort_grantStall", o_cpuStall, 1); adv();
        mid(); check("abort_issueAddr", o_ramAddr, 8'h40); check("abort_issueWe", o_ramWe, 0); adv();
        i_reset = 1'b0;
        mid(); check("abort_noDone", o_cDone, 0); check("abort_noWe", o_ramWe, 0); adv();
        i_reset = 1'b1; i_cReq = 1'b0;
        mid();
        check("rst_cDone",    o_cDone, 0);
        check("rst_dDone",    o_dDone, 0);
        check("rst_cRData",   o_cRData, 0);
        check("rst_dRData",   o_dRData, 0);
        check("rst_stall",    o_cpuStall, 0);
        check("rst_halted",   o_halted, 0);
        check("rst_ramAddr",  o_ramAddr, 0);
        check("rst_ramWe",    o_ramWe, 0);
        check("rst_ramWData", o_ramWData, 0);
        adv();

        // First C read after reset: addr 0x10 -> 0xA5, done at +2
        i_cReq = 1'b1; i_cWe = 1'b0; i_cAddr = 8'h10;
        mid(); check("rd10_stall0", o_cpuStall, 1); check("rd10_done0", o_cDone, 0); adv();
        mid(); check("rd10_addr", o_ramAddr, 8'h10); check("rd10_done1", o_cDone, 0); adv();
        mid(); check("rd10_done2", o_cDone, 1); check("rd10_data", o_cRData, 8'hA5); check("rd10_stall2", o_cpuStall, 0); adv();
        i_cReq = 1'b0;
        mid(); check("rd10_doneOff", o_cDone, 0); check("rd10_hold", o_cRData, 8'hA5); adv();

        // C write 0x3C -> 0x20, done at +1
        i_cReq = 1'b1; i_cWe = 1'b1; i_cAddr = 8'h20; i_cWData = 8'h3C;
        mid(); check("wr20_stall0", o_cpuStall, 1); check("wr20_we0", o_ramWe, 0); check("wr20_done0", o_cDone, 0); adv();
        mid();
        check("wr20_we1", o_ramWe, 1); check("wr20_addr", o_ramAddr, 8'h20);
        check("wr20_wdata", o_ramWData, 8'h3C); check("wr20_done1", o_cDone, 1); check("wr20_stall1", o_cpuStall, 0);
        adv();
        i_cReq = 1'b0; i_cWe = 1'b0;
        mid(); check("wr20_we2", o_ramWe, 0); check("wr20_done2", o_cDone, 0); check("wr20_stall2", o_cpuStall, 0); adv();

        // Read back 0x20
        i_cReq = 1'b1; i_cWe = 1'b0; i_cAddr = 8'h20;
        mid(); adv();
        mid(); check("rb20_done1", o_cDone, 0); adv();
        mid(); check("rb20_done2", o_cDone, 1); check("rb20_data", o_cRData, 8'h3C); adv();

        // Both ports writing continuously: C,C,C,C,D repeating
        i_cReq = 1'b1; i_cWe = 1'b1; i_cAddr = 8'h80; i_cWData = 8'h11;
        i_dReq = 1'b1; i_dWe = 1'b1; i_dAddr = 8'h81; i_dWData = 8'h22;
        for (int g = 0; g < 10; g++) begin
            mid(); check($sformatf("starve_idle%0d", g), {o_cDone, o_dDone}, 2'b00); adv();
            mid(); check($sformatf("starve_grant%0d", g), {o_cDone, o_dDone}, (g % 5 == 4) ? 2'b01 : 2'b10); adv();
        end
        i_dReq = 1'b0; i_dWe = 1'b0;

        // Halt raised during a C read
        i_cReq = 1'b1; i_cWe = 1'b0; i_cAddr = 8'h10;
        mid(); adv();
        i_dHalt = 1'b1;
        mid(); check("halt_issueHalted", o_halted, 0); check("halt_issueStall", o_cpuStall, 1); adv();
        mid(); check("halt_cDone", o_cDone, 1); check("halt_cData", o_cRData, 8'hA5); check("halt_rdStall", o_cpuStall, 1); check("halt_rdHalted", o_halted, 0); adv();
        i_cAddr = 8'h02;
        mid(); check("halt_entered", o_halted, 1); check("halt_stall", o_cpuStall, 1); check("halt_noC", o_cDone, 0); adv();

        for (int k = 0; k < 4; k++) begin
            i_dReq = 1'b1; i_dWe = 1'b1; i_dAddr = 8'(k); i_dWData = 8'(k + 1);
            mid();
            check($sformatf("hwr%0d_idleDone", k), {o_cDone, o_dDone}, 2'b00);
            check($sformatf("hwr%0d_halted", k), o_halted, 1);
            adv();
            mid();
            check($sformatf("hwr%0d_done", k), {o_cDone, o_dDone}, 2'b01);
            check($sformatf("hwr%0d_we", k), o_ramWe, 1);
            check($sformatf("hwr%0d_addr", k), o_ramAddr, k);
            check($sformatf("hwr%0d_wdata", k), o_ramWData, k + 1);
            check($sformatf("hwr%0d_stall", k), o_cpuStall, 1);
            adv();
        end
        i_dReq = 1'b0; i_dWe = 1'b0;
        mid(); check("halt_hold", o_halted, 1); check("halt_holdNoC", o_cDone, 0); adv();
        i_dHalt = 1'b0;
        mid(); check("unhalt_same", o_halted, 1); check("unhalt_stallSame", o_cpuStall, 1); adv();
        mid(); check("unhalt_next", o_halted, 0); check("unhalt_cStall", o_cpuStall, 1); adv();
        mid(); check("unhalt_addr", o_ramAddr, 8'h02); check("unhalt_done1", o_cDone, 0); adv();
        mid(); check("unhalt_done2", o_cDone, 1); check("unhalt_data", o_cRData, 8'h03); adv();
        i_cReq = 1'b0;

        // D reads back-to-back with request held
        i_dReq = 1'b1; i_dWe = 1'b0;
        for (int r = 0; r < 3; r++) begin
            i_dAddr = rdAddr[r];
            mid(); check($sformatf("drd%0d_idle", r), o_dDone, 0); adv();
            mid(); check($sformatf("drd%0d_issue", r), o_dDone, 0); check($sformatf("drd%0d_addr", r), o_ramAddr, rdAddr[r]); adv();
            mid();
            check($sformatf("drd%0d_done", r), {o_cDone, o_dDone}, 2'b01);
            check($sformatf("drd%0d_data", r), o_dRData, rdExp[r]);
            adv();
        end
        i_dReq = 1'b0;
        mid();
        check("drd_hold", o_dRData, 8'hA5);
        check("drd_cHold", o_cRData, 8'h03);
        check("drd_doneOff", o_dDone, 0);
        adv();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
